// File: rtl/rng_multi.sv
// Multi-channel Galois LFSR random source: per-channel seed derivation, warm-up discard,
// and a valid/ready (or free-running) output word built from the register state.
module rng_multi #(
    parameter int unsigned       N_CH       = 2,
    parameter int unsigned       LFSR_W     = 32,
    parameter logic [LFSR_W-1:0] POLY       = 32'h8020_0003,
    parameter int unsigned       OUT_W      = 16,
    parameter int unsigned       LO_BITS    = 5,
    parameter int unsigned       WARMUP     = 16,
    parameter int unsigned       FREE_RUN   = 0,
    parameter logic [LFSR_W-1:0] RESET_SEED = 32'h0000_0001
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [LFSR_W-1:0]        seed,
    input  logic                     seed_load,
    output logic [N_CH*OUT_W-1:0]    rnd,
    output logic                     rnd_valid,
    input  logic                     rnd_ready,
    output logic                     warming
);

    localparam int unsigned CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0]  lfsr_q [N_CH];
    logic [LFSR_W-1:0]  lfsr_d [N_CH];
    logic               do_load;
    logic               do_step;

    // Channel k seed: rotate left by k/2, invert odd channels, never allow the all-zero lock-up state.
    function automatic logic [LFSR_W-1:0] derive_seed(input logic [LFSR_W-1:0] s,
                                                      input int unsigned       k);
        int unsigned       r;
        logic [LFSR_W-1:0] v;
        r = (k >> 1) % LFSR_W;
        v = (r == 0) ? s : ((s << r) | (s >> (LFSR_W - r)));
        if ((k % 2) != 0) begin
            v = ~v;
        end
        if (v == '0) begin
            v = LFSR_W'(1);
        end
        return v;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_load = 1'b0;
        do_step = 1'b0;
        if (enable) begin
            if (seed_load) begin
                do_load = 1'b1;
                cnt_d   = CNT_W'(WARMUP);
                state_d = ST_WARMUP;
            end else begin
                unique case (state_q)
                    ST_WARMUP: begin
                        if (cnt_q == '0) begin
                            state_d = ST_RUN;
                        end else begin
                            do_step = 1'b1;
                            cnt_d   = cnt_q - CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if ((FREE_RUN != 0) || rnd_ready) begin
                            do_step = 1'b1;
                        end
                    end
                    default: state_d = ST_WARMUP;
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            lfsr_d[k] = lfsr_q[k];
            if (do_load) begin
                lfsr_d[k] = derive_seed(seed, k);
            end else if (do_step) begin
                lfsr_d[k] = lfsr_step(lfsr_q[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WARMUP;
            cnt_q   <= CNT_W'(WARMUP);
            for (int unsigned k = 0; k < N_CH; k++) begin
                lfsr_q[k] <= derive_seed(RESET_SEED, k);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int unsigned k = 0; k < N_CH; k++) begin
                lfsr_q[k] <= lfsr_d[k];
            end
        end
    end

    // Each output lane is the top OUT_W-LO_BITS state bits above the LO_BITS state LSBs.
    always_comb begin
        rnd = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            rnd[k*OUT_W +: OUT_W] = {lfsr_q[k][LFSR_W-1 -: OUT_W-LO_BITS], lfsr_q[k][LO_BITS-1:0]};
        end
    end

    assign rnd_valid = enable && (state_q == ST_RUN);
    assign warming   = (state_q == ST_WARMUP);

endmodule

// File: tb/tb_rng_multi.sv
// Randomised bench for rng_multi: three builds (WARMUP=0, default, 4-channel free-run)
// compared against a transaction-level LFSR model kept in the bench.
module tb_rng_multi;

    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk;
    logic        rst  [3];
    logic        en   [3];
    logic [31:0] sd   [3];
    logic        ld   [3];
    logic        rdy  [3];

    logic [31:0] r0, r1;
    logic [63:0] r2;
    logic        v0, v1, v2;
    logic        w0, w1, w2;

    int          n_chk;
    int          n_pass;
    logic [31:0] mst [3][4];
    int          nch [3];
    int          wu  [3];
    bit          fr  [3];

    rng_multi #(.WARMUP(0)) u_w0 (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .seed(sd[0]), .seed_load(ld[0]),
        .rnd(r0), .rnd_valid(v0), .rnd_ready(rdy[0]), .warming(w0)
    );

    rng_multi u_def (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .seed(sd[1]), .seed_load(ld[1]),
        .rnd(r1), .rnd_valid(v1), .rnd_ready(rdy[1]), .warming(w1)
    );

    rng_multi #(.N_CH(4), .WARMUP(3), .FREE_RUN(1)) u_fr4 (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .seed(sd[2]), .seed_load(ld[2]),
        .rnd(r2), .rnd_valid(v2), .rnd_ready(rdy[2]), .warming(w2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] chan_seed(input logic [31:0] s, input int k);
        logic [31:0] v;
        v = s;
        for (int j = 0; j < k / 2; j++) v = {v[30:0], v[31]};
        if (k % 2 == 1) v = ~v;
        if (v == 32'h0) v = 32'h1;
        return v;
    endfunction

    function automatic logic [15:0] slice16(input logic [31:0] s);
        return {s[31:21], s[4:0]};
    endfunction

    function automatic logic [63:0] exp_word(input int i);
        logic [63:0] w;
        w = 64'h0;
        for (int k = 0; k < nch[i]; k++) w[k*16 +: 16] = slice16(mst[i][k]);
        return w;
    endfunction

    function automatic logic [63:0] rdw(input int i);
        if (i == 0) return {32'h0, r0};
        if (i == 1) return {32'h0, r1};
        return r2;
    endfunction

    function automatic logic vld(input int i);
        if (i == 0) return v0;
        if (i == 1) return v1;
        return v2;
    endfunction

    function automatic logic wrm(input int i);
        if (i == 0) return w0;
        if (i == 1) return w1;
        return w2;
    endfunction

    task automatic model_seed(input int i, input logic [31:0] s);
        for (int k = 0; k < nch[i]; k++) mst[i][k] = chan_seed(s, k);
    endtask

    task automatic model_step(input int i);
        for (int k = 0; k < nch[i]; k++) mst[i][k] = lfsr_next(mst[i][k]);
    endtask

    task automatic model_load(input int i, input logic [31:0] s);
        model_seed(i, s);
        for (int j = 0; j < wu[i]; j++) model_step(i);
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input int i, input logic [31:0] s, input bit with_acc);
        en[i]  = 1'b1;
        sd[i]  = s;
        ld[i]  = 1'b1;
        rdy[i] = with_acc;
        settle;
        if (with_acc) check("accept_with_load", vld(i), 1'b1);
        tick;
        ld[i]  = 1'b0;
        rdy[i] = 1'b0;
        model_load(i, s);
    endtask

    // Counts not-yet-valid cycles (bounded), then checks the first delivered word.
    task automatic wait_warm(input int i, input int exp_cycles);
        int n;
        n = 0;
        rdy[i] = 1'b0;
        settle;
        while (!vld(i) && n < 100) begin
            check("warming_flag", wrm(i), 1'b1);
            n++;
            tick;
            settle;
        end
        check("warm_cycles", 64'(n), 64'(exp_cycles));
        check("first_word", rdw(i), exp_word(i));
        if (fr[i]) model_step(i);
        tick;
    endtask

    task automatic run_hs(input int i, input int n, input bit rand_en, input bit rand_rdy);
        for (int c = 0; c < n; c++) begin
            en[i]  = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy[i] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            settle;
            check("valid", vld(i), en[i]);
            check("warming_run", wrm(i), 1'b0);
            check("word", rdw(i), exp_word(i));
            if (en[i] && (fr[i] || rdy[i])) model_step(i);
            tick;
        end
    endtask

    initial begin
        logic [31:0] s;
        n_chk = 0;
        n_pass = 0;
        nch = '{2, 2, 4};
        wu  = '{0, 16, 3};
        fr  = '{1'b0, 1'b0, 1'b1};
        clk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; en[i] = 1'b1; sd[i] = 32'h0; ld[i] = 1'b0; rdy[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            model_seed(i, 32'h1);
            check("reset_word", rdw(i), exp_word(i));
            check("reset_valid", vld(i), 1'b0);
            check("reset_warming", wrm(i), 1'b1);
        end
        check("reset_const_ch01", rdw(0), 64'hFFFE_0001);
        check("reset_const_4ch", rdw(2), 64'hFFFD_0002_FFFE_0001);
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        tick;

        // WARMUP=0 build: seed 1 delivers the seed slice, then one step.
        do_load(0, 32'h1, 1'b0);
        wait_warm(0, 1);
        check("seed1_word0_const", rdw(0), 64'hFFFE_0001);
        rdy[0] = 1'b1;
        settle;
        model_step(0);
        tick;
        rdy[0] = 1'b0;
        settle;
        check("seed1_word1_const", rdw(0), 64'h7FFF_8023);
        check("seed1_word1_model", rdw(0), exp_word(0));
        tick;
        run_hs(0, 300, 1'b0, 1'b1);

        // All-zero seed must not lock up.
        do_load(0, 32'h0, 1'b0);
        wait_warm(0, 1);
        check("seed0_const", rdw(0), 64'hFFFF_0001);
        run_hs(0, 1000, 1'b0, 1'b0);

        // Back-pressure: word held for 10 cycles, one ready pulse gives exactly one step.
        rdy[0] = 1'b0;
        en[0]  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle;
            check("hold_valid", vld(0), 1'b1);
            check("hold_word", rdw(0), exp_word(0));
            tick;
        end
        rdy[0] = 1'b1;
        settle;
        check("pulse_word", rdw(0), exp_word(0));
        model_step(0);
        tick;
        rdy[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle;
            check("one_step", rdw(0), exp_word(0));
            tick;
        end

        // Load coincident with an accept: the load wins, no extra step.
        s = $urandom;
        do_load(0, s, 1'b1);
        wait_warm(0, 1);
        run_hs(0, 50, 1'b1, 1'b1);

        // Async reset in the middle of a pending handshake.
        en[0] = 1'b1; rdy[0] = 1'b0;
        settle;
        check("pre_reset_valid", vld(0), 1'b1);
        rst[0] = 1'b0;
        settle;
        model_seed(0, 32'h1);
        check("midhs_reset_valid", vld(0), 1'b0);
        check("midhs_reset_word", rdw(0), exp_word(0));
        check("midhs_reset_warming", wrm(0), 1'b1);
        tick;
        rst[0] = 1'b1;

        // Default build: 17 warm-up cycles, first word is step 16 of the seed.
        s = $urandom;
        do_load(1, s, 1'b0);
        wait_warm(1, 17);
        run_hs(1, 400, 1'b1, 1'b1);

        // Freeze during warm-up; a seed_load while disabled is ignored.
        s = $urandom;
        do_load(1, s, 1'b0);
        for (int c = 0; c < 5; c++) begin
            settle;
            check("warm_pre_freeze_valid", vld(1), 1'b0);
            tick;
        end
        en[1] = 1'b0; ld[1] = 1'b1; sd[1] = ~s;
        model_seed(1, s);
        for (int j = 0; j < 5; j++) model_step(1);
        for (int c = 0; c < 6; c++) begin
            settle;
            check("freeze_warming", wrm(1), 1'b1);
            check("freeze_valid", vld(1), 1'b0);
            check("freeze_word", rdw(1), exp_word(1));
            tick;
        end
        en[1] = 1'b1; ld[1] = 1'b0;
        model_load(1, s);
        wait_warm(1, 12);
        run_hs(1, 200, 1'b1, 1'b1);

        // Async reset mid warm-up, then warm-up restarts from the reset seed.
        s = $urandom;
        do_load(1, s, 1'b0);
        repeat (5) tick;
        rst[1] = 1'b0;
        settle;
        model_seed(1, 32'h1);
        check("midwarm_reset_word", rdw(1), exp_word(1));
        check("midwarm_reset_warming", wrm(1), 1'b1);
        check("midwarm_reset_valid", vld(1), 1'b0);
        tick;
        rst[1] = 1'b1;
        model_load(1, 32'h1);
        wait_warm(1, 17);

        // Four-channel free-running build.
        s = $urandom;
        do_load(2, s, 1'b0);
        settle;
        check("ch2_seed", 64'(rdw(2)[47:32]), 64'(slice16({s[30:0], s[31]})));
        check("ch3_seed", 64'(rdw(2)[63:48]), 64'(slice16(~{s[30:0], s[31]})));
        wait_warm(2, 4);
        run_hs(2, 10000, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rng_multi.md
Name: rng_multi

Overview:
Parametrised multi-channel random-number source, successor to the two-channel 16-bit LFSR generator. It instantiates N_CH Galois LFSRs, derives a distinct seed for each channel from one seed word, discards a programmable warm-up run after every seed, and delivers one N_CH-wide random word per valid/ready handshake (or per cycle in free-run mode). It feeds the stochastic-computing datapath that consumes several independent random streams.

Parameters:
N_CH, 2, number of independent LFSR channels (>=1)
LFSR_W, 32, LFSR state width
POLY, 32'h80200003, Galois right-shift feedback mask (bit LFSR_W-1 set; default is maximal-length for 32 bits)
OUT_W, 16, output bits per channel (LO_BITS < OUT_W <= LFSR_W)
LO_BITS, 5, number of state LSBs placed in the low part of each output
WARMUP, 16, LFSR steps discarded after each seed load (0 allowed)
FREE_RUN, 0, 1 = step every RUN cycle and ignore rnd_ready; 0 = step only on accept
RESET_SEED, 32'h0000_0001, seed applied by reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset (0 = in reset)
enable  input  1  1 = block advances; 0 = freeze all state
seed  input  LFSR_W  seed word, sampled when seed_load=1
seed_load  input  1  single-cycle request to reseed all channels
rnd  output  N_CH*OUT_W  channel k in bits [k*OUT_W +: OUT_W]
rnd_valid  output  1  rnd holds an unconsumed word
rnd_ready  input  1  consumer accepts rnd (ignored when FREE_RUN=1)
warming  output  1  1 while in WARMUP

Behaviour:
- Per-channel seed: s_k = rotl(S, k>>1) XOR (k odd ? all ones : 0). Channel 0 = S, channel 1 = ~S, channel 2 = rotl(S,1), channel 3 = ~rotl(S,1), etc. If any s_k == 0, that channel loads 1 instead.
- Step: next = (s >> 1) XOR (s[0] ? POLY : 0). All channels always step together.
- Output slice: rnd_k = {s_k[LFSR_W-1 -: OUT_W-LO_BITS], s_k[LO_BITS-1:0]}. rnd is driven directly from the state registers, with no combinational path from the inputs.
- Reset (async assert, sync release): channel states = derived RESET_SEED values; FSM = WARMUP; warm counter = WARMUP; rnd_valid = 0; warming = 1. rnd then shows the slice of the reset states.
- FSM states:
  - WARMUP: each enabled cycle, if the counter is 0, go to RUN without stepping. Otherwise step and decrement. warming = 1, rnd_valid = 0.
  - RUN: rnd_valid = 1 when enable = 1.
    - FREE_RUN=0: step on (rnd_valid & rnd_ready). The new word appears on the cycle after the accept.
    - FREE_RUN=1: step every enabled cycle.
- seed_load (enable=1) in any state: load derived seeds on the next edge, counter = WARMUP, go to WARMUP. It takes priority over a simultaneous step. An accept in the same cycle still counts as consumed; no extra step follows.
- enable = 0: no state change, rnd_valid = 0, seed_load ignored, warm counter held.
- WARMUP=0: a load is followed by exactly one WARMUP cycle with no step, then RUN. The first word delivered is the seed slice itself.
- Reset mid-WARMUP or mid-handshake: the async reset wins immediately and the pending word is discarded.
- rnd is stable while rnd_valid=1 and rnd_ready=0 (FREE_RUN=0).

Test Plan:
- Defaults, reset released, enable=1, seed=1 with seed_load, WARMUP=0, rnd_ready=1:
  - first valid rnd ch0=0x0001, ch1=0xFFFE
  - next word ch0=0x8023, ch1=0x7FFF
- seed=0 loaded: ch0 state = 1 (rnd ch0=0x0001), ch1 = 0xFFFFFFFF (rnd 0xFFFF), no lock-up over 1000 accepts.
- WARMUP=16, seed_load: warming=1 and rnd_valid=0 for exactly 17 cycles. The first word equals the 16th step of the seed (checked against a reference model).
- FREE_RUN=0, rnd_ready held 0 for 10 cycles: rnd unchanged and rnd_valid=1. After one ready pulse, exactly one step.
- enable toggled low during WARMUP and RUN: counter, states and rnd frozen, rnd_valid=0. Resume continues with the same sequence.
- seed_load asserted in the same cycle as an accept, and reset asserted mid-WARMUP: load wins with no extra step; async reset forces the reset values before the next edge.
- N_CH=4 build: ch2/ch3 seeds are rotl(S,1) and its complement. Model and RTL agree for 10k words.
